// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the load/store unit and dmem_ctrl.
// The load/store unit is the master, the memory the slave.
interface dmem_ctrl_if #(
    parameter int AW = 12
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [1:0]    req_mode;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          init_busy;

    modport master (
        output req_valid, req_wr, req_mode, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );

    modport slave (
        input  req_valid, req_wr, req_mode, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Handshaked word-organised data memory with byte-lane stores and extended loads.
// Define DMEM_CLEAR_ON_RESET_EN to zero the RAM with an INIT sweep after reset.
module dmem_ctrl #(
    parameter int DMEM_ADDR_WIDTH   = 12,
    parameter int DMEM_READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);

    localparam int WAW = DMEM_ADDR_WIDTH - 2;
    localparam int NW  = 2 ** WAW;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_e;

    state_e state_q, state_d;

    logic [31:0] mem_q [NW];

    logic           accept;
    logic           legal;
    logic           we;
    logic [3:0]     ben;
    logic [31:0]    wword;
    logic [WAW-1:0] widx;
    logic [WAW-1:0] ridx;
    logic [1:0]     off;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_wr_q,    s1_wr_d;
    logic        s1_err_q,   s1_err_d;
    logic        s1_uns_q,   s1_uns_d;
    logic [1:0]  s1_mode_q,  s1_mode_d;
    logic [1:0]  s1_off_q,   s1_off_d;
    logic [31:0] s1_word_q,  s1_word_d;
    logic [15:0] s1_sel;
    logic [31:0] s1_ext;
    logic [31:0] s1_rdata;
    logic        s1_rerr;

`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [WAW-1:0] init_cnt_q, init_cnt_d;
`endif

    assign off    = bus.req_addr[1:0];
    assign ridx   = bus.req_addr[DMEM_ADDR_WIDTH-1:2];
    assign accept = bus.req_valid & bus.req_ready;

    always_comb begin
        unique case (bus.req_mode)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~off[0];
            2'b10:   legal = (off == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Ready and busy are masked by rst so nothing is accepted on a reset edge.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.init_busy = 1'b0;
        we            = 1'b0;
        widx          = ridx;
        ben           = 4'h0;
        wword         = bus.req_wdata;
`ifdef DMEM_CLEAR_ON_RESET_EN
        init_cnt_d    = init_cnt_q;
`endif
        unique case (state_q)
`ifdef DMEM_CLEAR_ON_RESET_EN
            ST_INIT: begin
                bus.init_busy = ~rst;
                we            = ~rst;
                widx          = init_cnt_q;
                ben           = 4'hF;
                wword         = 32'h0;
                init_cnt_d    = init_cnt_q + 1'b1;
                if (init_cnt_q == WAW'(NW - 1))
                    state_d = ST_IDLE;
            end
`endif
            ST_IDLE: begin
                bus.req_ready = ~rst;
                we            = bus.req_valid & ~rst & bus.req_wr & legal;
                unique case (bus.req_mode)
                    2'b00: begin
                        ben   = 4'b0001 << off;
                        wword = {4{bus.req_wdata[7:0]}};
                    end
                    2'b01: begin
                        ben   = off[1] ? 4'b1100 : 4'b0011;
                        wword = {2{bus.req_wdata[15:0]}};
                    end
                    default: ben = 4'hF;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
`else
            state_q    <= ST_IDLE;
`endif
        end else begin
            state_q    <= state_d;
`ifdef DMEM_CLEAR_ON_RESET_EN
            init_cnt_q <= init_cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && ben[b])
                mem_q[widx][8*b +: 8] <= wword[8*b +: 8];
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_wr_d    = s1_wr_q;
        s1_err_d   = s1_err_q;
        s1_uns_d   = s1_uns_q;
        s1_mode_d  = s1_mode_q;
        s1_off_d   = s1_off_q;
        s1_word_d  = s1_word_q;
        if (accept) begin
            s1_wr_d   = bus.req_wr;
            s1_err_d  = ~legal;
            s1_uns_d  = bus.req_unsigned;
            s1_mode_d = bus.req_mode;
            s1_off_d  = off;
            s1_word_d = mem_q[ridx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_wr_q    <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_uns_q   <= 1'b0;
            s1_mode_q  <= 2'b00;
            s1_off_q   <= 2'b00;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_wr_q    <= s1_wr_d;
            s1_err_q   <= s1_err_d;
            s1_uns_q   <= s1_uns_d;
            s1_mode_q  <= s1_mode_d;
            s1_off_q   <= s1_off_d;
        end
        s1_word_q <= s1_word_d;
    end

    // Data is forced to zero outside a valid load so the bus idles at zero.
    always_comb begin
        s1_sel = 16'(s1_word_q >> {s1_off_q, 3'b000});
        unique case (s1_mode_q)
            2'b00:   s1_ext = {{24{~s1_uns_q & s1_sel[7]}}, s1_sel[7:0]};
            2'b01:   s1_ext = {{16{~s1_uns_q & s1_sel[15]}}, s1_sel};
            default: s1_ext = s1_word_q;
        endcase
        s1_rdata = (s1_valid_q & ~s1_wr_q & ~s1_err_q) ? s1_ext : 32'h0;
        s1_rerr  = s1_valid_q & s1_err_q;
    end

    generate
        if (DMEM_READ_LATENCY == 2) begin : g_lat2
            logic        s2_valid_q;
            logic [31:0] s2_rdata_q;
            logic        s2_err_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid_q <= 1'b0;
                    s2_rdata_q <= 32'h0;
                    s2_err_q   <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    s2_rdata_q <= s1_rdata;
                    s2_err_q   <= s1_rerr;
                end
            end

            assign bus.rsp_valid = s2_valid_q;
            assign bus.rsp_rdata = s2_rdata_q;
            assign bus.rsp_err   = s2_err_q;
        end else begin : g_lat1
            assign bus.rsp_valid = s1_valid_q;
            assign bus.rsp_rdata = s1_rdata;
            assign bus.rsp_err   = s1_rerr;
        end
    endgenerate

endmodule
